// File: rtl/neuron_accumulator_if.sv
// Streaming bus between the adder-tree stage, the neuron accumulator and the activation consumer.
// master drives partial sums and the result handshake; slave is the accumulator.
interface neuron_accumulator_if #(
   parameter int unsigned ACC_W = 26
);
   logic                 start;
   logic signed [ACC_W:0] bias;
   logic [19:0]          sum_in;
   logic                 sum_valid;
   logic                 busy;
   logic [7:0]           act_out;
   logic                 act_valid;
   logic                 act_ready;
   logic                 overrun;

   modport master (
      output start, bias, sum_in, sum_valid, act_ready,
      input  busy, act_out, act_valid, overrun
   );

   modport slave (
      input  start, bias, sum_in, sum_valid, act_ready,
      output busy, act_out, act_valid, overrun
   );
endinterface

// File: rtl/neuron_accumulator.sv
// Accumulates NUM_CHUNKS unsigned partial sums, adds a signed bias, then applies
// ReLU, a right shift and 8-bit saturation to produce one activation per neuron.
module neuron_accumulator #(
   parameter int unsigned NUM_CHUNKS = 49,
   parameter int unsigned ACC_W      = 26,
   parameter int unsigned OUT_SHIFT  = 12
) (
   input logic                 clk,
   input logic                 rst_n,
   neuron_accumulator_if.slave bus
);
   localparam int unsigned SUM_W = 20;
   localparam int unsigned CNT_W = $clog2(NUM_CHUNKS + 1);
   localparam int unsigned RES_W = ACC_W + 2;
   localparam int unsigned ACT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      BIAS   = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [ACC_W-1:0]        r_acc, w_acc_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic signed [ACC_W:0]   r_bias, w_bias_nxt;
   logic [ACT_W-1:0]        r_act, w_act_nxt;
   logic                    r_act_valid, w_act_valid_nxt;
   logic                    r_busy;
   logic                    r_overrun, w_overrun_nxt;

   logic signed [RES_W-1:0] w_res;
   logic [RES_W-1:0]        w_res_shr;
   logic [ACT_W-1:0]        w_act_sat;

   // Biased sum at full width, then ReLU and saturation to 8 bits.
   always_comb begin
      w_res     = $signed({2'b00, r_acc}) + $signed({r_bias[ACC_W], r_bias});
      w_res_shr = $unsigned(w_res) >> OUT_SHIFT;
      if (w_res[RES_W-1]) begin
         w_act_sat = '0;
      end else if (|w_res_shr[RES_W-1:ACT_W]) begin
         w_act_sat = '1;
      end else begin
         w_act_sat = w_res_shr[ACT_W-1:0];
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_bias_nxt      = r_bias;
      w_act_nxt       = r_act;
      w_act_valid_nxt = r_act_valid;
      // Upstream cannot be stalled, so a sum arriving outside ACCUM is lost and flagged.
      w_overrun_nxt   = bus.sum_valid && (r_state != ACCUM);

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
               w_bias_nxt  = bus.bias;
               w_state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.sum_valid) begin
               w_acc_nxt = r_acc + ACC_W'(bus.sum_in);
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(NUM_CHUNKS - 1)) begin
                  w_state_nxt = BIAS;
               end
            end
         end
         BIAS: begin
            w_act_nxt       = w_act_sat;
            w_act_valid_nxt = 1'b1;
            w_state_nxt     = OUTPUT;
         end
         OUTPUT: begin
            if (bus.act_ready) begin
               w_act_valid_nxt = 1'b0;
               w_state_nxt     = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_bias      <= '0;
         r_act       <= '0;
         r_act_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bias      <= w_bias_nxt;
         r_act       <= w_act_nxt;
         r_act_valid <= w_act_valid_nxt;
         r_busy      <= (w_state_nxt != IDLE);
         r_overrun   <= w_overrun_nxt;
      end
   end

   assign bus.busy      = r_busy;
   assign bus.act_out   = r_act;
   assign bus.act_valid = r_act_valid;
   assign bus.overrun   = r_overrun;

   if (SUM_W + $clog2(NUM_CHUNKS) > ACC_W) begin : g_acc_w_check
      $error("ACC_W too narrow for NUM_CHUNKS partial sums");
   end
endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized self-checking bench for neuron_accumulator against an arithmetic
// reference: sum of accepted chunks plus bias, ReLU, divide, clamp to 255.
module tb_neuron_accumulator;
   localparam int unsigned NUM_CHUNKS = 49;
   localparam int unsigned ACC_W      = 26;
   localparam int unsigned OUT_SHIFT  = 12;
   localparam int unsigned BW         = ACC_W + 1;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   neuron_accumulator_if #(.ACC_W(ACC_W)) u_if ();

   neuron_accumulator #(
      .NUM_CHUNKS (NUM_CHUNKS),
      .ACC_W      (ACC_W),
      .OUT_SHIFT  (OUT_SHIFT)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_act(input longint acc, input longint b);
      longint r;
      r = acc + b;
      if (r < 0) return 0;
      r = r / (longint'(1) << OUT_SHIFT);
      return (r > 255) ? 255 : int'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a neuron, feeds NUM_CHUNKS sums in [lo,hi] with random gaps and stops once act_valid is up.
   task automatic run_to_output(input longint b, input int unsigned lo, input int unsigned hi,
                                input int unsigned gap_pct, input bit noisy, input string name,
                                output int exp_act, output logic [7:0] got_act);
      longint      acc;
      int          n;
      int          cyc;
      int unsigned s;
      bit          saw_ovr;
      acc     = 0;
      n       = 0;
      cyc     = 0;
      saw_ovr = 1'b0;
      u_if.start     = 1'b1;
      u_if.bias      = BW'(b);
      u_if.sum_valid = 1'b0;
      tick();
      u_if.start = 1'b0;
      u_if.bias  = BW'(longint'($urandom));
      checks++;
      if (u_if.busy !== 1'b1) begin
         failures++;
         $display("FAIL %s start_busy got=%0b exp=1", name, u_if.busy);
      end
      while (n < int'(NUM_CHUNKS) && cyc < 5000) begin
         cyc++;
         if ($urandom_range(0, 99) < gap_pct) begin
            u_if.sum_valid = 1'b0;
         end else begin
            s              = $urandom_range(lo, hi);
            u_if.sum_valid = 1'b1;
            u_if.sum_in    = 20'(s);
            acc            = acc + longint'(s);
            n++;
         end
         u_if.start = noisy && ($urandom_range(0, 7) == 0);
         if (u_if.start) u_if.bias = BW'(longint'($urandom));
         tick();
         if (u_if.overrun !== 1'b0) saw_ovr = 1'b1;
      end
      u_if.sum_valid = 1'b0;
      u_if.start     = 1'b0;
      checks++;
      if (n != int'(NUM_CHUNKS)) begin
         failures++;
         $display("FAIL %s chunk_budget got=%0d exp=%0d", name, n, NUM_CHUNKS);
      end
      checks++;
      if (saw_ovr) begin
         failures++;
         $display("FAIL %s overrun_in_accum got=1 exp=0", name);
      end
      exp_act = model_act(acc, b);
      checks++;
      if (u_if.act_valid !== 1'b0 || u_if.busy !== 1'b1) begin
         failures++;
         $display("FAIL %s bias_cycle got valid=%0b busy=%0b exp valid=0 busy=1", name, u_if.act_valid, u_if.busy);
      end
      tick();
      checks++;
      if (u_if.act_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s act_valid_timing got=%0b exp=1", name, u_if.act_valid);
      end
      got_act = u_if.act_out;
      checks++;
      if (u_if.act_out !== 8'(exp_act)) begin
         failures++;
         $display("FAIL %s act_out got=%0d exp=%0d", name, u_if.act_out, exp_act);
      end
   endtask

   task automatic handshake(input int exp_act, input string name);
      u_if.act_ready = 1'b1;
      tick();
      u_if.act_ready = 1'b0;
      checks++;
      if (u_if.act_valid !== 1'b0 || u_if.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s handshake got valid=%0b busy=%0b exp 0/0", name, u_if.act_valid, u_if.busy);
      end
      checks++;
      if (u_if.act_out !== 8'(exp_act)) begin
         failures++;
         $display("FAIL %s act_out_retained got=%0d exp=%0d", name, u_if.act_out, exp_act);
      end
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      u_if.start     = 1'b0;
      u_if.bias      = '0;
      u_if.sum_in    = '0;
      u_if.sum_valid = 1'b0;
      u_if.act_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (u_if.busy !== 1'b0 || u_if.act_valid !== 1'b0 || u_if.overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got busy=%0b valid=%0b ovr=%0b exp 0/0/0", u_if.busy, u_if.act_valid, u_if.overrun);
      end
      checks++;
      if (u_if.act_out !== 8'd0) begin
         failures++;
         $display("FAIL reset_act_out got=%0d exp=0", u_if.act_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int         e;
      logic [7:0] g;
      run_to_output(0, 1000, 1000, 30, 1'b0, "basic", e, g);
      checks++;
      if (g !== 8'd11) begin
         failures++;
         $display("FAIL basic_const got=%0d exp=11", g);
      end
      handshake(e, "basic");
   endtask

   task automatic test_relu();
      int         e;
      logic [7:0] g;
      run_to_output(-60000, 1000, 1000, 0, 1'b0, "relu", e, g);
      checks++;
      if (g !== 8'd0) begin
         failures++;
         $display("FAIL relu_const got=%0d exp=0", g);
      end
      handshake(e, "relu");
   endtask

   task automatic test_saturate();
      int         e;
      logic [7:0] g;
      run_to_output(0, 1040400, 1040400, 20, 1'b0, "sat", e, g);
      checks++;
      if (g !== 8'd255) begin
         failures++;
         $display("FAIL sat_const got=%0d exp=255", g);
      end
      handshake(e, "sat");
   endtask

   task automatic test_random();
      int         e;
      logic [7:0] g;
      longint     b;
      for (int k = 0; k < 8; k++) begin
         b = longint'($urandom_range(0, 1200000)) - 600000;
         run_to_output(b, 0, 20000, 25, 1'b1, "random", e, g);
         handshake(e, "random");
      end
   endtask

   task automatic test_idle_overrun();
      u_if.sum_valid = 1'b1;
      u_if.sum_in    = 20'd5;
      tick();
      u_if.sum_valid = 1'b0;
      checks++;
      if (u_if.overrun !== 1'b1 || u_if.busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_overrun got ovr=%0b busy=%0b exp 1/0", u_if.overrun, u_if.busy);
      end
      tick();
      checks++;
      if (u_if.overrun !== 1'b0) begin
         failures++;
         $display("FAIL idle_overrun_pulse got=%0b exp=0", u_if.overrun);
      end
   endtask

   task automatic test_output_hold();
      int         e;
      logic [7:0] g;
      logic       sv;
      run_to_output(longint'($urandom_range(0, 200000)) - 100000, 0, 20000, 10, 1'b0, "hold", e, g);
      for (int i = 0; i < 5; i++) begin
         sv             = (i % 2 == 0);
         u_if.act_ready = 1'b0;
         u_if.start     = !sv;
         u_if.bias      = BW'(longint'($urandom));
         u_if.sum_valid = sv;
         u_if.sum_in    = 20'($urandom);
         tick();
         checks++;
         if (u_if.act_out !== 8'(e) || u_if.act_valid !== 1'b1 || u_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_stable got out=%0d valid=%0b busy=%0b exp %0d/1/1", u_if.act_out, u_if.act_valid, u_if.busy, e);
         end
         checks++;
         if (u_if.overrun !== sv) begin
            failures++;
            $display("FAIL hold_overrun got=%0b exp=%0b", u_if.overrun, sv);
         end
      end
      u_if.sum_valid = 1'b0;
      u_if.start     = 1'b1;
      handshake(e, "hold");
      u_if.start = 1'b0;
      tick();
      checks++;
      if (u_if.busy !== 1'b0 || u_if.act_out !== 8'(e)) begin
         failures++;
         $display("FAIL hold_start_ignored got busy=%0b out=%0d exp 0/%0d", u_if.busy, u_if.act_out, e);
      end
   endtask

   task automatic test_abort();
      int         e;
      logic [7:0] g;
      u_if.start = 1'b1;
      u_if.bias  = BW'(longint'(300000));
      tick();
      u_if.start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         u_if.sum_valid = 1'b1;
         u_if.sum_in    = 20'd30000;
         tick();
      end
      u_if.sum_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (u_if.busy !== 1'b0 || u_if.act_valid !== 1'b0 || u_if.overrun !== 1'b0) begin
         failures++;
         $display("FAIL abort_async got busy=%0b valid=%0b ovr=%0b exp 0/0/0", u_if.busy, u_if.act_valid, u_if.overrun);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_to_output(0, 1000, 1000, 15, 1'b0, "abort", e, g);
      checks++;
      if (g !== 8'd11) begin
         failures++;
         $display("FAIL abort_residue got=%0d exp=11", g);
      end
      handshake(e, "abort");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_relu();
      test_saturate();
      test_idle_overrun();
      test_random();
      test_output_hold();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
